pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter RESET_VEC, default 16'h0000: fetch address loaded on reset.
REQ-002 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port bre, input, 1: branch-resolved enable from the flag register decoder; a value of exactly 1 means take the branch.
REQ-005 Port br_target, input, 16: branch destination word address; sampled when bre=1.
REQ-006 Port stall, input, 1: downstream hold; freezes instruction handoff only.
REQ-007 Port imem_req, output, 1: instruction memory request.
REQ-008 Port imem_addr, output, 16: request word address; stable while imem_req=1.
REQ-009 Port imem_ack, input, 1: memory completes the request this cycle; imem_rdata is valid.
REQ-010 Port imem_rdata, input, 16: fetched instruction word.
REQ-011 Port ir, output, 16: instruction presented to decode.
REQ-012 Port ir_valid, output, 1: ir and pc are valid.
REQ-013 Port ir_ready, input, 1: decode accepts ir this cycle.
REQ-014 Port pc, output, 16: address of the instruction currently in ir.

Function
REQ-015 FSM states: REQ (request outstanding), HOLD (ir valid, awaiting accept), DRAIN (request outstanding, result to be discarded).
REQ-016 Internal fetch_pc: next address to fetch; imem_addr=fetch_pc in REQ and DRAIN; imem_req=1 in REQ and DRAIN only.
REQ-017 REQ, imem_ack=1, bre=0 -> ir<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+1, ir_valid<=1, go HOLD.
REQ-018 REQ, imem_ack=0, bre=0 -> stay in REQ; imem_req and imem_addr held unchanged.
REQ-019 HOLD, ir_ready=1, stall=0, bre=0 -> ir_valid<=0, go REQ; ir and pc are otherwise held.
REQ-020 HOLD with stall=1 -> ir_ready is ignored; state, ir, pc and ir_valid are held.
REQ-021 bre=1 in HOLD -> fetch_pc<=br_target, ir_valid<=0, go REQ; ir_ready and stall are ignored.
REQ-022 bre=1 in REQ with imem_ack=1 -> imem_rdata is discarded, fetch_pc<=br_target, go REQ; ir_valid stays 0.
REQ-023 bre=1 in REQ with imem_ack=0 -> fetch_pc_pending<=br_target, go DRAIN; the outstanding request is never withdrawn.
REQ-024 DRAIN holds imem_addr at the original address until imem_ack.
REQ-025 DRAIN on imem_ack -> data is discarded, fetch_pc<=pending target, go REQ.
REQ-026 bre=1 during DRAIN overwrites the pending target (last branch wins).
REQ-027 bre=1 coincident with imem_ack in DRAIN -> the new br_target is used.
REQ-028 Address arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, with no flag or error.
REQ-029 Latency: request to ir_valid = 1 cycle after the imem_ack edge; accept to the next imem_req = 1 cycle (one bubble per instruction).
REQ-030 A bre value other than 1 (0 or x) shall not change state; the bench flags x on bre as a violation.

Reset
REQ-031 While rst=1: state=REQ, fetch_pc=RESET_VEC, pending target=RESET_VEC, ir=16'h0000, pc=16'h0000, ir_valid=0, imem_req=0.
REQ-032 First rising edge after rst deasserts -> imem_req=1, imem_addr=RESET_VEC.
REQ-033 rst asserted mid-request abandons the request immediately; an imem_ack arriving during or after reset before a new request is ignored.

Structure
REQ-034 Widths (instruction 16, address 16), RESET_VEC default and the FSM state encodings are defined in the shared definitions include; no literal widths appear in the RTL.
REQ-035 The FSM, the fetch_pc register and the ir/pc output registers reside in pc_seq.
REQ-036 One sub-module, pc_incr (16-bit modulo incrementer), is instantiated for fetch_pc+1.
REQ-037 All outputs are registered except imem_req and imem_addr, which are decoded from the state register and fetch_pc.

Verification
REQ-038 Reset release, memory acks after 2 cycles with 16'hA001, 16'hA002 -> imem_addr 0000 then 0001; ir=A001 with pc=0000, then ir=A002 with pc=0001.
REQ-039 HOLD with stall=1 for 3 cycles and ir_ready=1 -> ir, pc and ir_valid held; advance on the first cycle with stall=0.
REQ-040 bre=1, br_target=16'h0040 while in HOLD -> ir_valid=0 next cycle; next imem_addr=0040.
REQ-041 bre=1, br_target=16'h0080 in REQ, ack delayed 3 cycles -> address held through DRAIN, returned word never reaches ir, next imem_addr=0080.
REQ-042 Two bre pulses in DRAIN, targets 0100 then 0200 -> next fetch at 0200.
REQ-043 br_target=16'hFFFF, ack -> pc=FFFF, next imem_addr=0000; rst pulsed mid-REQ -> outputs per REQ-031, late ack ignored.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: datapath widths,
// default reset vector and the fetch FSM state encoding.
package pc_seq_pkg;

  localparam int INSN_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_VEC_DEF = '0;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // request outstanding
    ST_HOLD  = 2'd1,  // ir valid, waiting for decode to accept
    ST_DRAIN = 2'd2   // request outstanding, its data will be dropped
  } state_t;

endpackage

// File: rtl/pc_incr.sv
// Modulo-2^W address incrementer; wraps all-ones to zero with no carry out.
module pc_incr
  import pc_seq_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign y = a + ONE;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: issues instruction fetches, hands fetched words
// to decode with their address, and redirects the fetch stream on branches.
// A request already issued to memory is never withdrawn; a branch that
// arrives while it is outstanding is parked until the memory acknowledges.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              bre,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [INSN_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0] pend_pc, pend_pc_n;
  logic [INSN_W-1:0] ir_n;
  logic [ADDR_W-1:0] pc_n;
  logic              ir_valid_n;
  // Cleared by reset; the state register sits in REQ during reset but no
  // request is live until the first clock edge after release, so any ack
  // seen before then must be ignored.
  logic              started;
  logic [ADDR_W-1:0] fetch_pc_inc;
  logic              take_br;

  pc_incr #(.W(ADDR_W)) u_incr (
    .a (fetch_pc),
    .y (fetch_pc_inc)
  );

  // Only an unambiguous 1 takes the branch; 0 or unknown leaves state alone.
  assign take_br = (bre == 1'b1);

  // Memory request is decoded straight from the state register and fetch_pc.
  assign imem_req  = started && ((state == ST_REQ) || (state == ST_DRAIN));
  assign imem_addr = fetch_pc;

  // State, fetch address, pending branch target and decode outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_VEC;
      pend_pc  <= RESET_VEC;
      ir       <= '0;
      pc       <= '0;
      ir_valid <= 1'b0;
      started  <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      pend_pc  <= pend_pc_n;
      ir       <= ir_n;
      pc       <= pc_n;
      ir_valid <= ir_valid_n;
      started  <= 1'b1;
    end
  end

  // Next-state and next-register decode for the fetch FSM.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    pend_pc_n  = pend_pc;
    ir_n       = ir;
    pc_n       = pc;
    ir_valid_n = ir_valid;

    if (!started) begin
      // First edge after reset only arms the request.
      state_n = ST_REQ;
    end else begin
      unique case (state)
        ST_REQ: begin
          if (imem_ack) begin
            if (take_br) begin
              // Returned word belongs to the wrong path: drop it, refetch.
              fetch_pc_n = br_target;
              state_n    = ST_REQ;
            end else begin
              ir_n       = imem_rdata;
              pc_n       = fetch_pc;
              fetch_pc_n = fetch_pc_inc;
              ir_valid_n = 1'b1;
              state_n    = ST_HOLD;
            end
          end else if (take_br) begin
            // Keep the live request on the bus; remember where to go next.
            pend_pc_n = br_target;
            state_n   = ST_DRAIN;
          end else begin
            state_n = ST_REQ;
          end
        end

        ST_HOLD: begin
          if (take_br) begin
            fetch_pc_n = br_target;
            ir_valid_n = 1'b0;
            state_n    = ST_REQ;
          end else if (!stall && ir_ready) begin
            ir_valid_n = 1'b0;
            state_n    = ST_REQ;
          end else begin
            state_n = ST_HOLD;
          end
        end

        ST_DRAIN: begin
          if (imem_ack) begin
            // A branch coincident with the ack is the newest one and wins.
            fetch_pc_n = take_br ? br_target : pend_pc;
            state_n    = ST_REQ;
          end else if (take_br) begin
            pend_pc_n = br_target;
            state_n   = ST_DRAIN;
          end else begin
            state_n = ST_DRAIN;
          end
        end

        default: begin
          ir_valid_n = 1'b0;
          state_n    = ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: a memory responder serves fetches, expected
// {pc, ir} pairs are queued when data is returned and compared when decode
// accepts the instruction.
module tb_pc_seq;

  logic        clock;
  logic        rst;
  logic        bre;
  logic [15:0] br_target;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] pc;

  int checks;
  int errors;
  logic [31:0] sb[$];

  pc_seq #(.RESET_VEC(16'h0000)) dut (
    .clock      (clock),
    .rst        (rst),
    .bre        (bre),
    .br_target  (br_target),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .pc         (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // An unknown branch enable is a protocol violation by the driver.
  always @(posedge clock) begin
    if (!rst && $isunknown(bre)) begin
      errors++;
      $display("FAIL bre_unknown: bre=%b required 0 or 1", bre);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic serve(input int delay, input logic [15:0] data);
    int n;
    logic [15:0] a;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL serve_req_timeout: imem_req=%b required 1", imem_req);
    end
    a = imem_addr;
    for (int i = 0; i < delay; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        errors++;
        $display("FAIL serve_addr_stable: req=%b addr=%h required req=1 addr=%h",
                 imem_req, imem_addr, a);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic accept();
    logic [31:0] e;
    checks++;
    if (ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL accept_valid: ir_valid=%b required 1", ir_valid);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL accept_sb_empty: got pc=%h ir=%h required nothing pending", pc, ir);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({pc, ir} !== e) begin
        errors++;
        $display("FAIL accept_data: pc=%h ir=%h required pc=%h ir=%h",
                 pc, ir, e[31:16], e[15:0]);
      end
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_clear: ir_valid=%b required 0", ir_valid);
    end
  endtask

  task automatic chk_addr(input string nm, input logic [15:0] exp);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h ir_valid=%b required req=1 addr=%h ir_valid=0",
               nm, imem_req, imem_addr, ir_valid, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bre = 1'b0; br_target = 16'h0000; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0000; ir_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 16'h0000 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b ir=%h pc=%h required 0 0 0000 0000",
               imem_req, ir_valid, ir, pc);
    end
    rst = 1'b0;
    tick();
    chk_addr("reset_release", 16'h0000);
  endtask

  task automatic test_fetch();
    sb.push_back({16'h0000, 16'hA001});
    serve(2, 16'hA001);
    accept();
    chk_addr("fetch_next1", 16'h0001);
    sb.push_back({16'h0001, 16'hA002});
    serve(2, 16'hA002);
    accept();
    chk_addr("fetch_next2", 16'h0002);
  endtask

  task automatic test_stall();
    logic [31:0] e;
    sb.push_back({16'h0002, 16'hB003});
    serve(0, 16'hB003);
    stall = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1 || ir !== 16'hB003 || pc !== 16'h0002 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid=%b ir=%h pc=%h req=%b required 1 b003 0002 0",
                 ir_valid, ir, pc, imem_req);
      end
    end
    stall = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({pc, ir} !== e) begin
      errors++;
      $display("FAIL stall_data: pc=%h ir=%h required pc=%h ir=%h", pc, ir, e[31:16], e[15:0]);
    end
    tick();
    ir_ready = 1'b0;
    chk_addr("stall_release", 16'h0003);
  endtask

  task automatic test_branch_hold();
    logic [31:0] e;
    sb.push_back({16'h0003, 16'hC004});
    serve(1, 16'hC004);
    e = sb.pop_front();
    checks++;
    if (ir_valid !== 1'b1 || {pc, ir} !== e) begin
      errors++;
      $display("FAIL br_hold_data: valid=%b pc=%h ir=%h required 1 pc=%h ir=%h",
               ir_valid, pc, ir, e[31:16], e[15:0]);
    end
    bre = 1'b1; br_target = 16'h0040;
    tick();
    bre = 1'b0;
    chk_addr("br_hold_redirect", 16'h0040);
  endtask

  task automatic test_branch_drain();
    bre = 1'b1; br_target = 16'h0080;
    tick();
    bre = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_addr("drain_addr_held", 16'h0040);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    chk_addr("drain_redirect", 16'h0080);
    sb.push_back({16'h0080, 16'hD005});
    serve(0, 16'hD005);
    accept();
    chk_addr("drain_after", 16'h0081);
  endtask

  task automatic test_last_branch_wins();
    bre = 1'b1; br_target = 16'h0300;
    tick();
    br_target = 16'h0100;
    tick();
    bre = 1'b0;
    tick();
    bre = 1'b1; br_target = 16'h0200;
    tick();
    bre = 1'b0;
    chk_addr("lbw_held", 16'h0081);
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    tick();
    imem_ack = 1'b0;
    chk_addr("lbw_target", 16'h0200);
    // Branch coincident with the draining ack takes the newer target.
    bre = 1'b1; br_target = 16'h0500;
    tick();
    br_target = 16'h0600; imem_ack = 1'b1;
    tick();
    bre = 1'b0; imem_ack = 1'b0;
    chk_addr("drain_coincident", 16'h0600);
  endtask

  task automatic test_wrap();
    bre = 1'b1; br_target = 16'hFFFF; imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    bre = 1'b0; imem_ack = 1'b0;
    chk_addr("req_br_ack", 16'hFFFF);
    sb.push_back({16'hFFFF, 16'hE006});
    serve(0, 16'hE006);
    accept();
    chk_addr("wrap_addr", 16'h0000);
  endtask

  task automatic test_reset_mid();
    sb.push_back({16'h0000, 16'hF007});
    serve(0, 16'hF007);
    accept();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 16'h0000 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: req=%b valid=%b ir=%h pc=%h required 0 0 0000 0000",
               imem_req, ir_valid, ir, pc);
    end
    imem_ack = 1'b1; imem_rdata = 16'hBAD1;
    tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    chk_addr("late_ack_ignored", 16'h0000);
    sb.push_back({16'h0000, 16'h1234});
    serve(0, 16'h1234);
    accept();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries required 0", sb.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_branch_hold();
    test_branch_drain();
    test_last_branch_wins();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
